// File: rtl/idu_decode_stage.sv
// RV32I instruction decode stage: decodes the fetched {pc, inst} packet and holds it
// in a one-entry pipeline register with valid/ready handshakes on both sides.
module idu_decode_stage #(
    parameter int CPU_Width = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_pre_valid,
    output logic                 o_pre_ready,
    input  logic [CPU_Width-1:0] i_ifu_pc,
    input  logic [CPU_Width-1:0] i_ifu_inst,
    input  logic                 i_flush,
    output logic                 o_post_valid,
    input  logic                 i_post_ready,
    output logic [CPU_Width-1:0] o_idu_pc,
    output logic [REG_IDX_W-1:0] o_rs1_idx,
    output logic [REG_IDX_W-1:0] o_rs2_idx,
    output logic [REG_IDX_W-1:0] o_rd_idx,
    output logic                 o_rd_wen,
    output logic [CPU_Width-1:0] o_imm,
    output logic [3:0]           o_alu_op,
    output logic                 o_src1_pc,
    output logic                 o_src2_imm,
    output logic [2:0]           o_br_type,
    output logic [1:0]           o_jump,
    output logic                 o_mem_ren,
    output logic                 o_mem_wen,
    output logic [1:0]           o_mem_size,
    output logic                 o_mem_unsigned,
    output logic                 o_ebreak,
    output logic                 o_ecall,
    output logic                 o_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef enum logic {EMPTY, FULL} state_e;

    typedef struct packed {
        logic [CPU_Width-1:0] pc;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic                 rd_wen;
        logic [CPU_Width-1:0] imm;
        logic [3:0]           alu_op;
        logic                 src1_pc;
        logic                 src2_imm;
        logic [2:0]           br_type;
        logic [1:0]           jump;
        logic                 mem_ren;
        logic                 mem_wen;
        logic [1:0]           mem_size;
        logic                 mem_unsigned;
        logic                 ebreak;
        logic                 ecall;
        logic                 illegal;
    } pkt_t;

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    state_e      state, state_next;
    pkt_t        dec, pkt_q;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] inst;
    logic [31:0] imm32;
    logic        legal;
    logic        rd_write;
    logic        full;
    logic        accept;

    assign inst   = i_ifu_inst[31:0];
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    // NOTE: every variable written here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        dec          = '0;
        imm32        = '0;
        legal        = 1'b1;
        rd_write     = 1'b0;
        dec.pc       = i_ifu_pc;
        dec.rs1      = REG_IDX_W'(inst[19:15]);
        dec.rs2      = REG_IDX_W'(inst[24:20]);
        dec.rd       = REG_IDX_W'(inst[11:7]);
        dec.alu_op   = ALU_ADD;

        // Every recognised opcode ends in 2'b11, so compressed encodings fall to default.
        case (opcode)
            OPC_OP: begin
                rd_write   = 1'b1;
                dec.alu_op = alu_from_f3(funct3, funct7[5]);
                legal      = (funct7 == 7'h00) ||
                             (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OPC_OP_IMM: begin
                rd_write     = 1'b1;
                imm32        = {{20{inst[31]}}, inst[31:20]};
                dec.src2_imm = 1'b1;
                dec.alu_op   = alu_from_f3(funct3, (funct3 == 3'b101) & inst[30]);
                if (funct3 == 3'b001)      legal = (funct7 == 7'h00);
                else if (funct3 == 3'b101) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
            end
            OPC_LUI: begin
                rd_write     = 1'b1;
                imm32        = {inst[31:12], 12'b0};
                dec.alu_op   = ALU_PASSB;
                dec.src2_imm = 1'b1;
            end
            OPC_AUIPC: begin
                rd_write     = 1'b1;
                imm32        = {inst[31:12], 12'b0};
                dec.src1_pc  = 1'b1;
                dec.src2_imm = 1'b1;
            end
            OPC_JAL: begin
                // Operand B is the link offset 4, which execute substitutes for o_imm.
                rd_write     = 1'b1;
                imm32        = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                dec.src1_pc  = 1'b1;
                dec.src2_imm = 1'b1;
                dec.jump     = 2'd1;
            end
            OPC_JALR: begin
                rd_write     = 1'b1;
                imm32        = {{20{inst[31]}}, inst[31:20]};
                dec.src1_pc  = 1'b1;
                dec.src2_imm = 1'b1;
                dec.jump     = 2'd2;
                legal        = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                imm32      = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                dec.alu_op = ALU_SUB;
                case (funct3)
                    3'b000:  dec.br_type = 3'd1;
                    3'b001:  dec.br_type = 3'd2;
                    3'b100:  dec.br_type = 3'd3;
                    3'b101:  dec.br_type = 3'd4;
                    3'b110:  dec.br_type = 3'd5;
                    3'b111:  dec.br_type = 3'd6;
                    default: legal       = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                rd_write         = 1'b1;
                imm32            = {{20{inst[31]}}, inst[31:20]};
                dec.src2_imm     = 1'b1;
                dec.mem_ren      = 1'b1;
                dec.mem_size     = funct3[1:0];
                dec.mem_unsigned = funct3[2];
                legal            = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OPC_STORE: begin
                imm32        = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                dec.src2_imm = 1'b1;
                dec.mem_wen  = 1'b1;
                dec.mem_size = funct3[1:0];
                legal        = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            end
            OPC_SYSTEM: begin
                dec.ebreak = (inst == 32'h0010_0073);
                dec.ecall  = (inst == 32'h0000_0073);
                legal      = dec.ebreak | dec.ecall;
            end
            default: legal = 1'b0;
        endcase

        dec.imm     = CPU_Width'($signed(imm32));
        dec.illegal = ~legal;
        dec.rd_wen  = rd_write & legal & (dec.rd != '0);
        // Illegal packets still flow to execute so it can trap, but with no side effects.
        if (!legal) begin
            dec.mem_ren = 1'b0;
            dec.mem_wen = 1'b0;
            dec.br_type = 3'd0;
            dec.jump    = 2'd0;
        end
    end

    assign full        = (state == FULL);
    assign o_pre_ready = ~full | i_post_ready;
    assign accept      = i_pre_valid & o_pre_ready & ~i_flush;

    always_comb begin
        state_next = state;
        if (i_flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (accept) state_next = FULL;
                FULL:    if (!accept && i_post_ready) state_next = EMPTY;
                default: state_next = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= state_next;
    end

    // NOTE: a one-entry pipeline register is cheap to reset, and doing so keeps the
    // outputs at a defined zero rather than X before the first packet arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        pkt_q <= '0;
        else if (accept) pkt_q <= dec;
    end

    assign o_post_valid   = full;
    assign o_idu_pc       = pkt_q.pc;
    assign o_rs1_idx      = pkt_q.rs1;
    assign o_rs2_idx      = pkt_q.rs2;
    assign o_rd_idx       = pkt_q.rd;
    assign o_rd_wen       = pkt_q.rd_wen;
    assign o_imm          = pkt_q.imm;
    assign o_alu_op       = pkt_q.alu_op;
    assign o_src1_pc      = pkt_q.src1_pc;
    assign o_src2_imm     = pkt_q.src2_imm;
    assign o_br_type      = pkt_q.br_type;
    assign o_jump         = pkt_q.jump;
    assign o_mem_ren      = pkt_q.mem_ren;
    assign o_mem_wen      = pkt_q.mem_wen;
    assign o_mem_size     = pkt_q.mem_size;
    assign o_mem_unsigned = pkt_q.mem_unsigned;
    assign o_ebreak       = pkt_q.ebreak;
    assign o_ecall        = pkt_q.ecall;
    assign o_illegal      = pkt_q.illegal;

endmodule

// File: tb/tb_idu_decode_stage.sv
// Directed bench for idu_decode_stage: expected packets are queued as they are offered
// and compared when the stage presents them, alongside a handshake model.
module tb_idu_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        src1_pc;
        logic        src2_imm;
        logic [2:0]  br_type;
        logic [1:0]  jump;
        logic        mem_ren;
        logic        mem_wen;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        ebreak;
        logic        ecall;
        logic        illegal;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_pre_valid;
    logic        o_pre_ready;
    logic [31:0] i_ifu_pc;
    logic [31:0] i_ifu_inst;
    logic        i_flush;
    logic        o_post_valid;
    logic        i_post_ready;
    logic [31:0] o_idu_pc;
    logic [4:0]  o_rs1_idx, o_rs2_idx, o_rd_idx;
    logic        o_rd_wen;
    logic [31:0] o_imm;
    logic [3:0]  o_alu_op;
    logic        o_src1_pc, o_src2_imm;
    logic [2:0]  o_br_type;
    logic [1:0]  o_jump;
    logic        o_mem_ren, o_mem_wen;
    logic [1:0]  o_mem_size;
    logic        o_mem_unsigned, o_ebreak, o_ecall, o_illegal;

    pkt_t dut_pkt;
    pkt_t cur_exp;
    pkt_t e;
    pkt_t sb_q[$];
    logic model_full = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    idu_decode_stage #(.CPU_Width(32), .REG_IDX_W(5)) dut (
        .clk(clk), .rst(rst),
        .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
        .i_ifu_pc(i_ifu_pc), .i_ifu_inst(i_ifu_inst), .i_flush(i_flush),
        .o_post_valid(o_post_valid), .i_post_ready(i_post_ready),
        .o_idu_pc(o_idu_pc), .o_rs1_idx(o_rs1_idx), .o_rs2_idx(o_rs2_idx), .o_rd_idx(o_rd_idx),
        .o_rd_wen(o_rd_wen), .o_imm(o_imm), .o_alu_op(o_alu_op),
        .o_src1_pc(o_src1_pc), .o_src2_imm(o_src2_imm), .o_br_type(o_br_type), .o_jump(o_jump),
        .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen), .o_mem_size(o_mem_size),
        .o_mem_unsigned(o_mem_unsigned), .o_ebreak(o_ebreak), .o_ecall(o_ecall),
        .o_illegal(o_illegal)
    );

    assign dut_pkt = {o_idu_pc, o_rs1_idx, o_rs2_idx, o_rd_idx, o_rd_wen, o_imm, o_alu_op,
                      o_src1_pc, o_src2_imm, o_br_type, o_jump, o_mem_ren, o_mem_wen,
                      o_mem_size, o_mem_unsigned, o_ebreak, o_ecall, o_illegal};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic pkt_t base(input logic [31:0] pc, input logic [31:0] inst);
        pkt_t p = '0;
        p.pc  = pc;
        p.rs1 = inst[19:15];
        p.rs2 = inst[24:20];
        p.rd  = inst[11:7];
        return p;
    endfunction

    task automatic offer(input logic [31:0] pc, input logic [31:0] inst, input pkt_t exp);
        i_pre_valid = 1'b1;
        i_ifu_pc    = pc;
        i_ifu_inst  = inst;
        cur_exp     = exp;
    endtask

    // Called just after a falling edge with inputs set for the coming rising edge.
    task automatic tick();
        logic exp_ready;
        logic acc;
        pkt_t dropped;
        #1;
        exp_ready = !model_full || i_post_ready;
        check("pre_ready", 128'(o_pre_ready), 128'(exp_ready));
        check("post_valid", 128'(o_post_valid), 128'(model_full));
        if (model_full) begin
            if (sb_q.size() == 0) check("sb_underflow", 128'(1), 128'(0));
            else                  check("packet", 128'(dut_pkt), 128'(sb_q[0]));
        end
        acc = i_pre_valid && exp_ready && !i_flush;
        if (i_flush) begin
            if (model_full && sb_q.size() != 0) dropped = sb_q.pop_front();
            model_full = 1'b0;
        end else begin
            if (model_full && i_post_ready && sb_q.size() != 0) dropped = sb_q.pop_front();
            if (acc) sb_q.push_back(cur_exp);
            model_full = acc ? 1'b1 : (i_post_ready ? 1'b0 : model_full);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        i_pre_valid  = 1'b0;
        i_ifu_pc     = '0;
        i_ifu_inst   = '0;
        i_flush      = 1'b0;
        i_post_ready = 1'b1;

        // Reset: outputs cleared, ready high, nothing captured even with a valid offer.
        #3;
        check("rst_post_valid", 128'(o_post_valid), 128'(0));
        check("rst_pre_ready", 128'(o_pre_ready), 128'(1));
        check("rst_packet", 128'(dut_pkt), 128'(0));
        @(negedge clk);
        i_pre_valid = 1'b1;
        i_ifu_inst  = 32'h0050_0093;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_hold_valid", 128'(o_post_valid), 128'(0));
        check("rst_hold_packet", 128'(dut_pkt), 128'(0));
        @(negedge clk);
        rst         = 1'b1;
        i_pre_valid = 1'b0;
        tick();
        tick();

        // Streaming with the consumer always ready.
        e = base(32'h8000_0000, 32'h0050_0093);                       // addi x1,x0,5
        e.rd_wen = 1; e.imm = 32'd5; e.src2_imm = 1;
        offer(32'h8000_0000, 32'h0050_0093, e); tick();
        e = base(32'h8000_0004, 32'hFE20_8EE3);                       // beq x1,x2,-4
        e.imm = 32'hFFFF_FFFC; e.alu_op = 4'd1; e.br_type = 3'd1;
        offer(32'h8000_0004, 32'hFE20_8EE3, e); tick();
        e = base(32'h8000_0008, 32'h1234_5137);                       // lui x2,0x12345
        e.rd_wen = 1; e.imm = 32'h1234_5000; e.alu_op = 4'd10; e.src2_imm = 1;
        offer(32'h8000_0008, 32'h1234_5137, e); tick();

        // Backpressure: three stalled cycles, then the waiting packet enters with no bubble.
        e = base(32'h8000_000C, 32'h0020_81B3);                       // add x3,x1,x2
        e.rd_wen = 1;
        offer(32'h8000_000C, 32'h0020_81B3, e);
        i_post_ready = 1'b0;
        tick(); tick(); tick();
        i_post_ready = 1'b1;
        tick();
        e = base(32'h8000_0010, 32'h4020_82B3);                       // sub x5,x1,x2
        e.rd_wen = 1; e.alu_op = 4'd1;
        offer(32'h8000_0010, 32'h4020_82B3, e); tick();
        e = base(32'h8000_0014, 32'h4030_D313);                       // srai x6,x1,3
        e.rd_wen = 1; e.imm = 32'h0000_0403; e.alu_op = 4'd7; e.src2_imm = 1;
        offer(32'h8000_0014, 32'h4030_D313, e); tick();
        e = base(32'h8000_0018, 32'hFF81_2383);                       // lw x7,-8(x2)
        e.rd_wen = 1; e.imm = 32'hFFFF_FFF8; e.src2_imm = 1; e.mem_ren = 1; e.mem_size = 2'd2;
        offer(32'h8000_0018, 32'hFF81_2383, e); tick();
        e = base(32'h8000_001C, 32'h0031_2623);                       // sw x3,12(x2)
        e.imm = 32'd12; e.src2_imm = 1; e.mem_wen = 1; e.mem_size = 2'd2;
        offer(32'h8000_001C, 32'h0031_2623, e); tick();
        e = base(32'h8000_0020, 32'h0100_00EF);                       // jal x1,16
        e.rd_wen = 1; e.imm = 32'd16; e.src1_pc = 1; e.src2_imm = 1; e.jump = 2'd1;
        offer(32'h8000_0020, 32'h0100_00EF, e); tick();
        e = base(32'h8000_0024, 32'h0010_0013);                       // addi x0,x0,1: rd=0
        e.imm = 32'd1; e.src2_imm = 1;
        offer(32'h8000_0024, 32'h0010_0013, e); tick();
        e = base(32'h8000_0028, 32'h0000_0000);                       // all-zero word
        e.illegal = 1;
        offer(32'h8000_0028, 32'h0000_0000, e); tick();
        e = base(32'h8000_002C, 32'h0010_0073);                       // ebreak
        e.ebreak = 1;
        offer(32'h8000_002C, 32'h0010_0073, e); tick();

        // Flush while FULL and stalled: the held and the offered packet both vanish.
        e = base(32'h8000_0030, 32'h0090_0493);                       // addi x9,x0,9
        e.rd_wen = 1; e.imm = 32'd9; e.src2_imm = 1;
        offer(32'h8000_0030, 32'h0090_0493, e);
        i_post_ready = 1'b0;
        i_flush      = 1'b1;
        tick();
        i_flush      = 1'b0;
        i_pre_valid  = 1'b0;
        i_post_ready = 1'b1;
        tick();
        tick();
        e = base(32'h8000_0040, 32'h0000_0073);                       // ecall
        e.ecall = 1;
        offer(32'h8000_0040, 32'h0000_0073, e); tick();

        // Drain with a bounded number of cycles.
        i_pre_valid = 1'b0;
        for (int i = 0; i < 4 && model_full; i++) tick();
        tick();
        check("sb_empty", 128'(sb_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
